// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter slice.
// Bus command values follow the system bus encoding from sys_defs.vh.
package mem_arb_pkg;

  localparam logic [1:0] BUS_NONE  = 2'h0;
  localparam logic [1:0] BUS_LOAD  = 2'h1;
  localparam logic [1:0] BUS_STORE = 2'h2;

  localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

endpackage

// File: rtl/mem_arb_select.sv
// Grant decision for the memory arbiter: data port wins unless fetch has been
// passed over STARVE_LIMIT times in a row while waiting.
module mem_arb_select import mem_arb_pkg::*; #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_req,
  input  logic   i_dreq,
  input  logic   i_idle,
  input  logic   i_grant,
  output owner_t o_owner
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] r_starveCnt;
  logic          w_starved;

  assign w_starved = (r_starveCnt == CW'(STARVE_LIMIT));

  always_comb begin
    o_owner = OWN_NONE;
    if (i_dreq && !(i_req && w_starved))
      o_owner = OWN_D;
    else if (i_req)
      o_owner = OWN_I;
  end

  // Counts data grants that bypassed a waiting fetch; any fetch grant or an
  // idle cycle without a fetch request forgives the history.
  always_ff @(posedge clk) begin
    if (rst)
      r_starveCnt <= '0;
    else if (i_grant && o_owner == OWN_I)
      r_starveCnt <= '0;
    else if (i_grant && o_owner == OWN_D && i_req) begin
      if (!w_starved)
        r_starveCnt <= r_starveCnt + 1'b1;
    end
    else if (i_idle && !i_req)
      r_starveCnt <= '0;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises IF-stage fetches and MEM-stage data accesses onto one memory bus.
// Define ARB_TIMEOUT_EN to abort transactions whose mem_ack never arrives.
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic [1:0]        d_cmd,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err
);

  arb_state_t        r_state;
  owner_t            r_owner;
  owner_t            w_owner;
  logic [1:0]        r_cmd;
  logic [1:0]        r_memCmd;
  logic [ADDR_W-1:0] r_memAddr;
  logic [DATA_W-1:0] r_memWdata;
  logic [DATA_W-1:0] r_iRdata;
  logic [DATA_W-1:0] r_dRdata;
  logic              r_iReady;
  logic              r_dReady;
  logic              w_dReq;
  logic              w_idle;
  logic              w_grant;
  logic              w_ack;
  logic              w_abort;
  logic [DATA_W-1:0] w_respData;

  assign w_dReq  = d_req && (d_cmd != BUS_NONE);
  assign w_idle  = (r_state == IDLE);
  assign w_grant = w_idle && (w_owner != OWN_NONE);
  assign w_ack   = mem_ack && (r_state == ISSUE || r_state == WAIT);

  mem_arb_select #(.STARVE_LIMIT(STARVE_LIMIT)) u_select (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_req),
    .i_dreq  (w_dReq),
    .i_idle  (w_idle),
    .i_grant (w_grant),
    .o_owner (w_owner)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_tmoCnt;
  logic          r_err;

  // Starts from zero on every grant so ISSUE plus TIMEOUT-1 WAIT cycles elapse before abort.
  always_ff @(posedge clk) begin
    if (rst || w_grant)
      r_tmoCnt <= '0;
    else if (r_state == ISSUE || r_state == WAIT)
      r_tmoCnt <= r_tmoCnt + 1'b1;
  end

  assign w_abort    = !mem_ack && (r_state == WAIT) && (r_tmoCnt == TW'(TIMEOUT - 1));
  assign w_respData = w_abort ? DATA_W'(DEADBEEF) : mem_rdata;
  assign err        = r_err;
`else
  assign w_abort    = 1'b0;
  assign w_respData = mem_rdata;
  assign err        = 1'b0;
`endif

  // Single-owner transaction FSM; every bus and response output is a register
  // loaded on the transition into the state where it must be visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_owner    <= OWN_NONE;
      r_cmd      <= BUS_NONE;
      r_memCmd   <= BUS_NONE;
      r_memAddr  <= '0;
      r_memWdata <= '0;
      r_iRdata   <= '0;
      r_dRdata   <= '0;
      r_iReady   <= 1'b0;
      r_dReady   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_err      <= 1'b0;
`endif
    end else begin
      r_memCmd <= BUS_NONE;
      r_iReady <= 1'b0;
      r_dReady <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_err    <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_owner <= w_owner;
            r_state <= ISSUE;
            if (w_owner == OWN_D) begin
              r_cmd      <= d_cmd;
              r_memCmd   <= d_cmd;
              r_memAddr  <= d_addr;
              r_memWdata <= d_wdata;
            end else begin
              r_cmd     <= BUS_LOAD;
              r_memCmd  <= BUS_LOAD;
              r_memAddr <= i_addr;
            end
          end
        end
        ISSUE, WAIT: begin
          if (w_ack || w_abort) begin
            r_state <= RESP;
            if (r_owner == OWN_I) begin
              r_iReady <= 1'b1;
              r_iRdata <= w_respData;
            end else begin
              r_dReady <= 1'b1;
              if (r_cmd == BUS_LOAD || w_abort)
                r_dRdata <= w_respData;
            end
`ifdef ARB_TIMEOUT_EN
            r_err <= w_abort;
`endif
          end else begin
            r_state <= WAIT;
          end
        end
        RESP: begin
          r_state <= IDLE;
          r_owner <= OWN_NONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign i_ready   = r_iReady;
  assign i_rdata   = r_iRdata;
  assign d_ready   = r_dReady;
  assign d_rdata   = r_dRdata;
  assign mem_cmd   = r_memCmd;
  assign mem_addr  = r_memAddr;
  assign mem_wdata = r_memWdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural memory and reference image.
// Build with ARB_TIMEOUT_EN defined to exercise the abort path.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 16;
  localparam int MAX_WAIT     = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic [31:0] i_rdata;
  logic        d_req;
  logic [1:0]  d_cmd;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic [1:0]  mem_cmd;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        err;

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_cmd(d_cmd), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; logic err; } resp_t;
  typedef struct { logic [1:0] cmd; logic [31:0] addr; logic [31:0] wdata; } bus_t;

  resp_t       iExpQ[$];
  resp_t       dExpQ[$];
  bus_t        iBusQ[$];
  bus_t        dBusQ[$];
  bit          grantLog[$];
  logic [31:0] refMem [bit [31:0]];
  logic [31:0] busMem [bit [31:0]];
  logic [31:0] lastD = 32'h0;
  int          checks = 0;
  int          errors = 0;
  int          ackMode = 1;
  bit          strayAck = 1'b0;
  bit          allowDrop = 1'b0;
  int          cycle = 0;
  int          iStart, iReadyCycle, dReadyCycle, iCmdCycle, dCmdCycle;
  logic [1:0]  prevCmd = 2'h0;

  always @(posedge clk) cycle <= cycle + 1;

  // The memory image starts from a fixed address hash in both the bench
  // memory and the reference copy.
  function automatic logic [31:0] initWord(bit [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] refRead(bit [31:0] a);
    if (refMem.exists(a)) return refMem[a];
    return initWord(a);
  endfunction

  function automatic logic [31:0] busRead(bit [31:0] a);
    if (busMem.exists(a)) return busMem[a];
    return initWord(a);
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic failNow(string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s", name);
  endtask

  task automatic checkResetValues(string tag);
    checkOutput({tag, "_mem_cmd"},   32'(mem_cmd),   32'(BUS_NONE));
    checkOutput({tag, "_mem_addr"},  mem_addr,       32'h0);
    checkOutput({tag, "_mem_wdata"}, mem_wdata,      32'h0);
    checkOutput({tag, "_i_ready"},   32'(i_ready),   32'h0);
    checkOutput({tag, "_d_ready"},   32'(d_ready),   32'h0);
    checkOutput({tag, "_err"},       32'(err),       32'h0);
    checkOutput({tag, "_i_rdata"},   i_rdata,        32'h0);
    checkOutput({tag, "_d_rdata"},   d_rdata,        32'h0);
  endtask

  // Memory model: performs each bus command and acks after a delay chosen by
  // ackMode (0 random 0..3, 1 one cycle after ISSUE, 2 never).
  initial begin
    int          delay;
    bit          pending;
    logic [31:0] data;
    delay = 0; pending = 1'b0; data = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      if (rst) pending = 1'b0;
      else if (mem_cmd != BUS_NONE && ackMode != 2) begin
        if (mem_cmd == BUS_STORE) begin
          busMem[mem_addr] = mem_wdata;
          data = $urandom;
        end else data = busRead(mem_addr);
        delay = (ackMode == 1) ? 1 : int'($urandom_range(0, 3));
        pending = 1'b1;
      end
      if (pending) begin
        if (delay == 0) begin
          mem_ack = 1'b1; mem_rdata = data; pending = 1'b0;
        end else delay--;
      end
      if (strayAck) begin
        mem_ack = 1'b1; strayAck = 1'b0;
      end
    end
  end

  // Monitor: compares every ready pulse and every bus command with the queues.
  initial begin
    resp_t r;
    bus_t  b;
    forever begin
      @(negedge clk);
      if (rst) prevCmd = BUS_NONE;
      else begin
        if (i_ready) begin
          iReadyCycle = cycle;
          if (iExpQ.size() == 0) failNow($sformatf("unexpected_i_ready at cycle %0d", cycle));
          else begin
            r = iExpQ.pop_front();
            checkOutput("i_rdata", i_rdata, r.data);
            checkOutput("i_err", 32'(err), 32'(r.err));
          end
        end
        if (d_ready) begin
          dReadyCycle = cycle;
          if (dExpQ.size() == 0) failNow($sformatf("unexpected_d_ready at cycle %0d", cycle));
          else begin
            r = dExpQ.pop_front();
            checkOutput("d_rdata", d_rdata, r.data);
            checkOutput("d_err", 32'(err), 32'(r.err));
          end
        end
        if (mem_cmd != BUS_NONE) begin
          checkOutput("cmd_one_cycle", 32'(prevCmd), 32'(BUS_NONE));
          grantLog.push_back(mem_addr[9]);
          if (mem_addr[9]) begin
            dCmdCycle = cycle;
            if (dBusQ.size() == 0) failNow("unexpected_d_bus_cmd");
            else begin
              b = dBusQ.pop_front();
              checkOutput("d_mem_cmd", 32'(mem_cmd), 32'(b.cmd));
              checkOutput("d_mem_addr", mem_addr, b.addr);
              if (b.cmd == BUS_STORE) checkOutput("d_mem_wdata", mem_wdata, b.wdata);
            end
          end else begin
            iCmdCycle = cycle;
            if (iBusQ.size() == 0) failNow("unexpected_i_bus_cmd");
            else begin
              b = iBusQ.pop_front();
              checkOutput("i_mem_cmd", 32'(mem_cmd), 32'(b.cmd));
              checkOutput("i_mem_addr", mem_addr, b.addr);
            end
          end
        end
        prevCmd = mem_cmd;
      end
    end
  end

  // Holds the request until its ready pulse; once granted, the address and
  // data are scrambled (and optionally the request dropped), which must not matter.
  task automatic waitReady(bit isD, string name);
    bit seen = 1'b0;
    for (int k = 0; k < MAX_WAIT && !seen; k++) begin
      @(negedge clk);
      if (isD ? d_ready : i_ready) seen = 1'b1;
      else if (!isD && iBusQ.size() == 0) begin
        i_addr = $urandom;
        if (allowDrop && $urandom_range(0, 3) == 0) i_req = 1'b0;
      end else if (isD && dBusQ.size() == 0) begin
        d_addr = $urandom; d_wdata = $urandom;
        if (allowDrop && $urandom_range(0, 3) == 0) d_req = 1'b0;
      end
    end
    if (!seen) failNow($sformatf("%s: no ready within %0d cycles", name, MAX_WAIT));
  endtask

  task automatic issueI(logic [31:0] addr);
    resp_t r;
    bus_t  b;
    r.data = refRead(addr); r.err = 1'b0;
    iExpQ.push_back(r);
    b.cmd = BUS_LOAD; b.addr = addr; b.wdata = 32'h0;
    iBusQ.push_back(b);
    iStart = cycle;
    i_req = 1'b1; i_addr = addr;
    waitReady(1'b0, "i_ready_wait");
    i_req = 1'b0; i_addr = $urandom;
  endtask

  task automatic issueD(logic [1:0] cmd, logic [31:0] addr, logic [31:0] wdata, bit expectAbort);
    resp_t r;
    bus_t  b;
    if (expectAbort) r.data = 32'hDEAD_BEEF;
    else if (cmd == BUS_STORE) r.data = lastD;
    else r.data = refRead(addr);
    if (cmd == BUS_STORE && !expectAbort) refMem[addr] = wdata;
    if (cmd == BUS_LOAD || expectAbort) lastD = r.data;
    r.err = expectAbort;
    dExpQ.push_back(r);
    b.cmd = cmd; b.addr = addr; b.wdata = wdata;
    dBusQ.push_back(b);
    d_req = 1'b1; d_cmd = cmd; d_addr = addr; d_wdata = wdata;
    waitReady(1'b1, "d_ready_wait");
    d_req = 1'b0; d_cmd = BUS_NONE;
  endtask

  // Idle data port in one of the two non-request encodings.
  task automatic idleD();
    if ($urandom_range(0, 1) == 1) begin d_req = 1'b1; d_cmd = BUS_NONE; end
    else begin d_req = 1'b0; d_cmd = BUS_LOAD; end
    d_addr = 32'h200 + 32'($urandom_range(0, 31)) * 4;
  endtask

  task automatic applyStimulus();
    int expOwner;
    bit seen;
    // reset state
    rst = 1'b1; i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_cmd = BUS_NONE; d_addr = 32'h0; d_wdata = 32'h0;
    refMem[32'h100] = 32'h0050_0093;
    busMem[32'h100] = 32'h0050_0093;
    repeat (3) @(negedge clk);
    checkResetValues("in_reset");
    rst = 1'b0;
    @(negedge clk);
    checkResetValues("after_reset");

    // single fetch with ack one cycle after ISSUE
    ackMode = 1;
    issueI(32'h100);
    checkOutput("fetch_latency", 32'(iReadyCycle - iStart), 32'd3);

    // store leaves d_rdata untouched
    issueD(BUS_STORE, 32'h200, 32'hCAFE_F00D, 1'b0);
    issueD(BUS_LOAD, 32'h200, 32'h0, 1'b0);

    // simultaneous first requests: data first, fetch in the following IDLE cycle
    @(negedge clk);
    grantLog.delete();
    fork
      issueI(32'h104);
      issueD(BUS_LOAD, 32'h204, 32'h0, 1'b0);
    join
    checkOutput("simul_grants", 32'(grantLog.size()), 32'd2);
    if (grantLog.size() >= 2) begin
      checkOutput("simul_first_is_d", 32'(grantLog[0]), 32'd1);
      checkOutput("simul_second_is_i", 32'(grantLog[1]), 32'd0);
    end
    checkOutput("i_issue_after_d_ready", 32'(iCmdCycle - dReadyCycle), 32'd2);

    // both ports saturated: every (STARVE_LIMIT+1)th grant goes to fetch
    @(negedge clk);
    grantLog.delete();
    fork
      begin repeat (2) issueI(32'($urandom_range(0, 127)) * 4); end
      begin repeat (8) issueD(BUS_LOAD, 32'h200 + 32'($urandom_range(0, 31)) * 4, 32'h0, 1'b0); end
    join
    checkOutput("starve_grants", 32'(grantLog.size()), 32'd10);
    for (int k = 0; k < 10; k++) begin
      expOwner = (((k + 1) % (STARVE_LIMIT + 1)) == 0) ? 0 : 1;
      if (k < grantLog.size())
        checkOutput($sformatf("starve_grant_%0d", k), 32'(grantLog[k]), 32'(expOwner));
    end

    // reset during WAIT, then a stray ack
    ackMode = 2;
    begin
      bus_t b;
      b.cmd = BUS_LOAD; b.addr = 32'h240; b.wdata = 32'h0;
      dBusQ.push_back(b);
    end
    d_req = 1'b1; d_cmd = BUS_LOAD; d_addr = 32'h240;
    seen = 1'b0;
    for (int k = 0; k < MAX_WAIT && !seen; k++) begin
      @(negedge clk);
      if (dBusQ.size() == 0) seen = 1'b1;
    end
    if (!seen) failNow("reset_test: grant never seen");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; d_req = 1'b0; d_cmd = BUS_NONE;
    lastD = 32'h0;
    @(negedge clk);
    strayAck = 1'b1;
    repeat (3) @(negedge clk);
    checkResetValues("after_mid_reset");
    ackMode = 1;
    issueD(BUS_LOAD, 32'h208, 32'h0, 1'b0);

    // randomised traffic with random ack latency and mid-transaction drops
    ackMode = 0;
    allowDrop = 1'b1;
    fork
      begin
        for (int n = 0; n < 25; n++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          issueI(32'($urandom_range(0, 127)) * 4);
        end
      end
      begin
        for (int n = 0; n < 25; n++) begin
          idleD();
          repeat ($urandom_range(0, 3)) @(negedge clk);
          issueD(($urandom_range(0, 1) == 1) ? BUS_STORE : BUS_LOAD,
                 32'h200 + 32'($urandom_range(0, 31)) * 4, $urandom, 1'b0);
        end
        idleD();
      end
    join
    allowDrop = 1'b0;
    d_req = 1'b0; d_cmd = BUS_NONE;
    repeat (2) @(negedge clk);

    // memory that never answers
    ackMode = 2;
`ifdef ARB_TIMEOUT_EN
    issueD(BUS_LOAD, 32'h2F0, 32'h0, 1'b1);
    checkOutput("timeout_latency", 32'(dReadyCycle - dCmdCycle), 32'(TIMEOUT));
    @(negedge clk);
    checkOutput("err_clears", 32'(err), 32'h0);
`else
    begin
      bus_t b;
      b.cmd = BUS_LOAD; b.addr = 32'h2F0; b.wdata = 32'h0;
      dBusQ.push_back(b);
    end
    d_req = 1'b1; d_cmd = BUS_LOAD; d_addr = 32'h2F0;
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (d_ready) seen = 1'b1;
    end
    checkOutput("wait_holds_no_ready", 32'(seen), 32'h0);
    checkOutput("wait_holds_mem_cmd", 32'(mem_cmd), 32'(BUS_NONE));
    checkOutput("wait_holds_d_rdata", d_rdata, lastD);
    checkOutput("wait_holds_err", 32'(err), 32'h0);
    d_req = 1'b0; d_cmd = BUS_NONE;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`endif
    checkOutput("queues_drained", 32'(iExpQ.size() + dExpQ.size() + iBusQ.size() + dBusQ.size()), 32'h0);
  endtask

  initial begin
    applyStimulus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
